// File: rtl/vote_session_ctrl.sv
// Ballot session sequencer: opens a voting window, collects one ballot per cycle, publishes a majority result.
// Optional quorum check enabled by defining VOTE_QUORUM_EN.
module vote_session_ctrl #(
  parameter int N       = 7,
  parameter int TIMEOUT = 32,
  parameter int QUORUM  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1,
  localparam int CW = $clog2(N + 1),
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic          vote_valid,
  input  logic [IW-1:0] vote_id,
  input  logic          vote_yes,
  output logic          vote_ready,
  output logic          vote_err,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [CW-1:0] yes_cnt,
  output logic [CW-1:0] no_cnt,
  output logic          quorum_fail
);

  typedef enum logic [1:0] {IDLE, COLLECT, TALLY} state_t;

  localparam int PW = 2 ** IW;

  if (QUORUM < 1 || QUORUM > N) begin : g_bad_quorum
    $error("vote_session_ctrl: QUORUM out of range");
  end

  state_t        r_state;
  logic [N-1:0]  r_seen;
  logic [CW-1:0] r_yes;
  logic [CW-1:0] r_no;
  logic [TW-1:0] r_timer;
  logic          r_err;
  logic          r_done;
  logic          r_pass;
  logic          r_qfail;

  logic [PW-1:0] w_seen_pad;
  logic [PW-1:0] w_onehot;
  logic          w_id_ok;
  logic          w_take;
  logic [CW:0]   w_total_next;
  logic          w_exit;
  logic          w_majority;

  always_comb begin
    w_seen_pad   = PW'(r_seen);
    w_onehot     = PW'(1) << vote_id;
    w_id_ok      = (32'(vote_id) < N) && !w_seen_pad[vote_id];
    w_take       = vote_valid && w_id_ok;
    w_total_next = (CW+1)'(r_yes) + (CW+1)'(r_no) + (CW+1)'(w_take);
    w_exit       = (w_total_next == (CW+1)'(N)) || (r_timer == TW'(TIMEOUT - 1));
    w_majority   = ({1'b0, r_yes} << 1) > (CW+1)'(N);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_seen  <= '0;
      r_yes   <= '0;
      r_no    <= '0;
      r_timer <= '0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_qfail <= 1'b0;
    end else begin
      r_err  <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start && !abort) begin
            r_state <= COLLECT;
            r_seen  <= '0;
            r_yes   <= '0;
            r_no    <= '0;
            r_timer <= '0;
            r_pass  <= 1'b0;
            r_qfail <= 1'b0;
          end
        end
        COLLECT: begin
          if (abort) begin
            r_state <= IDLE;
            r_pass  <= 1'b0;
          end else begin
            r_timer <= r_timer + 1'b1;
            if (vote_valid) begin
              if (w_id_ok) begin
                r_seen <= r_seen | w_onehot[N-1:0];
                if (vote_yes) r_yes <= r_yes + 1'b1;
                else          r_no  <= r_no + 1'b1;
              end else begin
                r_err <= 1'b1;
              end
            end
            if (w_exit) r_state <= TALLY;
          end
        end
        TALLY: begin
          r_state <= IDLE;
          if (abort) begin
            r_pass <= 1'b0;
          end else begin
            r_done <= 1'b1;
`ifdef VOTE_QUORUM_EN
            if ((CW+1)'(r_yes) + (CW+1)'(r_no) < (CW+1)'(QUORUM)) begin
              r_pass  <= 1'b0;
              r_qfail <= 1'b1;
            end else begin
              r_pass  <= w_majority;
              r_qfail <= 1'b0;
            end
`else
            r_pass  <= w_majority;
            r_qfail <= 1'b0;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign vote_ready  = (r_state == COLLECT);
  assign busy        = (r_state != IDLE);
  assign vote_err    = r_err;
  assign done        = r_done;
  assign pass        = r_pass;
  assign yes_cnt     = r_yes;
  assign no_cnt      = r_no;
  assign quorum_fail = r_qfail;

endmodule

// File: doc/vote_session_ctrl.md
Name: vote_session_ctrl

Overview:
Sequences one N-voter ballot session around a majority tally. It opens a voting window on start and accepts one ballot per cycle from a shared vote bus via a valid/ready handshake. It rejects duplicate and out-of-range voters, closes the window when all N have voted or a timeout expires, then registers the pass/fail result and the tallies. It sits between the voter-side request logic and any consumer of the decision.

Parameters:
N, 7, number of eligible voters (N >= 2)
TIMEOUT, 32, max cycles the window stays open (>= 1)
QUORUM, 4, minimum ballots cast for a valid result (used only with VOTE_QUORUM_EN; 1 <= QUORUM <= N)
Derived, not overridable: IW = ceil(log2(N)); CW = bits to hold value N; TW = bits to hold TIMEOUT-1

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  open a session; honoured only in IDLE
abort  input  1  synchronous cancel of the current session
vote_valid  input  1  ballot present on vote bus
vote_id  input  IW  voter index, 0..N-1
vote_yes  input  1  1 = yes, 0 = no
vote_ready  output  1  ballot accepted this cycle if vote_valid is also high
vote_err  output  1  one-cycle pulse: ballot rejected (duplicate or id >= N)
busy  output  1  state != IDLE
done  output  1  one-cycle pulse when a result is published
pass  output  1  result: strict majority of electorate voted yes
yes_cnt  output  CW  yes ballots in last/current session
no_cnt  output  CW  no ballots in last/current session
quorum_fail  output  1  last result invalid for lack of quorum (0 when feature absent)

Behaviour:
- Reset (rst_n low, async): state IDLE; every output 0; ballot bitmap, counts and timer 0.
- States: IDLE, COLLECT, TALLY.
- IDLE: vote_ready=0. When start=1, go to COLLECT next cycle and clear bitmap, yes_cnt, no_cnt, timer, pass and quorum_fail. Ballots in IDLE are ignored with no vote_err.
- COLLECT: vote_ready=1. A ballot is taken when vote_valid & vote_ready.
  - If vote_id < N and its bitmap bit is 0: set the bit, increment yes_cnt or no_cnt.
  - If the bit is already set, or vote_id >= N: counts unchanged, vote_err=1 on the next cycle.
  - The timer increments every COLLECT cycle.
  - Exit to TALLY when (yes_cnt+no_cnt reaches N including this cycle's ballot) or timer == TIMEOUT-1. A ballot accepted on the exit cycle is counted.
- TALLY: one cycle, vote_ready=0. Register pass = (2*yes_cnt > N), using CW+1-bit arithmetic. Pulse done. Return to IDLE.
- Latency: last ballot accepted in cycle t gives TALLY in t+1; done and pass are visible in t+2. Timeout gives done exactly TIMEOUT+1 cycles after the first COLLECT cycle.
- Abstentions, i.e. voters who never vote, count against pass.
- pass, yes_cnt, no_cnt and quorum_fail hold until the next accepted start.
- start while busy: ignored.
- abort=1 in COLLECT or TALLY: go to IDLE next cycle, no done, pass forced 0, counts held. abort has priority over exit and start.
- Simultaneous start and abort in IDLE: abort wins, stay IDLE.

Optional Feature:
VOTE_QUORUM_EN
- Defined: in TALLY, if yes_cnt+no_cnt < QUORUM then pass=0 and quorum_fail=1; otherwise quorum_fail=0 and pass follows the majority rule.
- Undefined: the QUORUM parameter is unused, quorum_fail is tied to 0, and pass follows only the majority rule.

Test Plan:
- N=7. start, then 7 distinct ids, 4 yes and 3 no, one per cycle -> exit after 7th ballot; done 2 cycles later; pass=1, yes_cnt=4, no_cnt=3.
- N=7, TIMEOUT=32. start, then 3 yes only -> done at cycle 33 after COLLECT entry; pass=0, yes_cnt=3, no_cnt=0.
- Duplicate id 2 sent twice, then id 7 (out of range) -> vote_err pulses twice; counts reflect a single ballot from id 2.
- abort 5 cycles into COLLECT -> busy falls next cycle, no done, pass=0; a following start opens a fresh session with zeroed counts.
- rst_n low mid-COLLECT -> all outputs 0 immediately, state IDLE; start while busy ignored (counts not cleared).
- VOTE_QUORUM_EN, QUORUM=4, 3 yes then timeout -> pass=0, quorum_fail=1. With the macro undefined -> quorum_fail=0, pass=0.
